pc_sequencer: RTL

Program counter and fetch sequencer. It sits directly downstream of the branch decision logic and consumes its pc_load output together with the calculated target address. It holds the architectural PC, drives a request/ready handshake to instruction memory, and advances the PC to either PC+4 or the target once control signals that the current instruction is complete. A misaligned-target trap state is included.

---
 rtl/pc_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: holds the PC, runs the imem request/ready
// handshake and advances to PC+4 or a branch target. Optional retire counter: PC_RETIRE_COUNT_EN.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_load,
  input  logic [XLEN-1:0] target,
  input  logic            advance,
  input  logic            stall,
  input  logic            trap_clear,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  output logic            misaligned,
  output logic [31:0]     retire_count
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic            req_q;
  logic            valid_q;
  logic            mis_q;

  logic            adv_acc;
  logic            tgt_misaligned;
  logic [XLEN-1:0] pc_inc;

  assign pc_inc         = pc_q + FOUR;
  assign adv_acc        = (state_q == EXEC) && advance && !stall;
  assign tgt_misaligned = (target[1:0] != 2'b00);

  // Outputs are registered alongside the state so each is a clean flop output;
  // the async reset therefore drops imem_req without waiting for an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HOLD;
      pc_q    <= RESET_VECTOR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem_ready && !stall) begin
            state_q <= EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        EXEC: begin
          if (adv_acc) begin
            valid_q <= 1'b0;
            if (pc_load && tgt_misaligned) begin
              state_q <= TRAP;
              mis_q   <= 1'b1;
            end else begin
              state_q <= FETCH;
              req_q   <= 1'b1;
              pc_q    <= pc_load ? target : pc_inc;
            end
          end
        end
        TRAP: begin
          if (trap_clear && !stall) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            req_q   <= 1'b1;
            mis_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= HOLD;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          mis_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_RETIRE_COUNT_EN
  logic [31:0] rc_q;

  // Counts every accepted advance, including the one that enters TRAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rc_q <= '0;
    end else if (adv_acc) begin
      rc_q <= rc_q + 32'd1;
    end
  end

  assign retire_count = rc_q;
`else
  assign retire_count = 32'd0;
`endif

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign pc_plus4    = pc_inc;
  assign imem_req    = req_q;
  assign instr_valid = valid_q;
  assign misaligned  = mis_q;

endmodule
